// File: rtl/logic_unit_pipe_pkg.sv
// Shared op-code constants and types for the pipelined logic unit.
`ifndef LOGIC_UNIT_PIPE_DEFS
`define LOGIC_UNIT_PIPE_DEFS
`define OP_W     3
`define OP_NAND  3'b000
`define OP_NOTA  3'b001
`define OP_AND   3'b010
`define OP_OR    3'b011
`define OP_XOR   3'b100
`define OP_NOR   3'b101
`define OP_XNOR  3'b110
`define OP_PASSB 3'b111
`endif

package logic_unit_pipe_pkg;
    localparam int OP_W = `OP_W;

    localparam logic [OP_W-1:0] op_nand  = `OP_NAND;
    localparam logic [OP_W-1:0] op_nota  = `OP_NOTA;
    localparam logic [OP_W-1:0] op_and   = `OP_AND;
    localparam logic [OP_W-1:0] op_or    = `OP_OR;
    localparam logic [OP_W-1:0] op_xor   = `OP_XOR;
    localparam logic [OP_W-1:0] op_nor   = `OP_NOR;
    localparam logic [OP_W-1:0] op_xnor  = `OP_XNOR;
    localparam logic [OP_W-1:0] op_passb = `OP_PASSB;
endpackage

// File: rtl/logic_unit_pipe_core.sv
// Combinational op decoder: result plus zero and parity flags.
module logic_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    // Full 3-bit decode, so every op value maps to a defined function.
    always_comb begin
        result = '0;
        case (op)
            `OP_NAND:  result = ~(a & b);
            `OP_NOTA:  result = ~a;
            `OP_AND:   result = a & b;
            `OP_OR:    result = a | b;
            `OP_XOR:   result = a ^ b;
            `OP_NOR:   result = ~(a | b);
            `OP_XNOR:  result = ~(a ^ b);
            `OP_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    assign zero   = (result == '0);
    assign parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit with chain forwarding of operand A.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic [WIDTH-1:0] last_result;

    logic [WIDTH-1:0] s1_res;
    logic             s1_zero;
    logic             s1_parity;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] a_eff;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (s1_res),
        .zero   (s1_zero),
        .parity (s1_parity)
    );

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    // Held low during reset so nothing is offered as accepted while clearing.
    assign in_ready = (!s1_valid || s2_free) && !rst;
    assign accept   = in_valid && in_ready;

    // A chained op reads the op still in S1 directly; once S1 is empty the
    // previous result lives in last_result. Acceptance implies S1 advances
    // this same edge, so the forwarded value is the one being retired.
    always_comb begin
        a_eff = a;
        if (chain) a_eff = s1_valid ? s1_res : last_result;
    end

    // S1: operand register, refilled on accept, emptied on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a_eff;
            s1_b     <= b;
            s1_op    <= op;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            parity    <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            y         <= s1_res;
            zero      <= s1_zero;
            parity    <= s1_parity;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // last_result tracks the most recently retired S1 result for chaining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_result <= '0;
        else if (s1_adv) last_result <= s1_res;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
    import logic_unit_pipe_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      a;
    logic [3:0]      b;
    logic [OP_W-1:0] op;
    logic            chain;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      y;
    logic            zero;
    logic            parity;

    int checks = 0;
    int errors = 0;

    logic_unit_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .chain     (chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                         input logic [OP_W-1:0] ov, input logic ch);
        in_valid = v; a = av; b = bv; op = ov; chain = ch;
    endtask

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b0, 4'h0, 4'h0, op_nand, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || y !== 4'h0 || zero !== 1'b0 || parity !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b y=%b zero=%b parity=%b in_ready=%b, want 0 0000 0 0 0",
                     out_valid, y, zero, parity, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_op_sweep;
        logic [3:0] ey [8];
        logic       ep [8];
        ey[0] = 4'b0111; ey[1] = 4'b0011; ey[2] = 4'b1000; ey[3] = 4'b1110;
        ey[4] = 4'b0110; ey[5] = 4'b0001; ey[6] = 4'b1001; ey[7] = 4'b1010;
        ep[0] = 1; ep[1] = 0; ep[2] = 1; ep[3] = 1; ep[4] = 0; ep[5] = 1; ep[6] = 0; ep[7] = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_latency: out_valid=%b one cycle after accept, want 0", out_valid);
                end
            end
            if (i >= 2 && i < 10) begin
                checks++;
                if (out_valid !== 1'b1 || y !== ey[i-2] || parity !== ep[i-2] || zero !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_op%0d: valid=%b y=%b parity=%b zero=%b, want 1 %b %b 0",
                             i-2, out_valid, y, parity, zero, ey[i-2], ep[i-2]);
                end
            end
            if (i == 10) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_drain: out_valid=%b want 0", out_valid);
                end
            end
            if (i < 8) drive(1'b1, 4'b1100, 4'b1010, 3'(i), 1'b0);
            else       drive(1'b0, 4'b1100, 4'b1010, op_nand, 1'b0);
        end
    endtask

    task automatic test_zero_flag;
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 4'b1100, 4'b0011, op_and, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'b0000, 4'b0000, op_nand, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== 4'b0000 || zero !== 1'b1 || parity !== 1'b0) begin
            errors++;
            $display("FAIL zero_flag: valid=%b y=%b zero=%b parity=%b, want 1 0000 1 0",
                     out_valid, y, zero, parity);
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] q[$];
        logic [3:0] nxt;
        logic [3:0] prev_y;
        logic       prev_stall;
        int         recv;
        nxt = 4'd1; recv = 0; prev_stall = 1'b0; prev_y = 4'h0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || y !== prev_y) begin
                    errors++;
                    $display("FAIL bp_hold c%0d: valid=%b y=%b, want 1 %b", c, out_valid, y, prev_y);
                end
            end
            out_ready = !(c >= 3 && c < 8);
            drive(nxt <= 4'd10, 4'h0, nxt, op_passb, 1'b0);
            #1;
            if (c >= 3 && c < 8) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: unexpected result y=%b, want none", y);
                end else begin
                    if (y !== q[0]) begin
                        errors++;
                        $display("FAIL bp_order: got %b want %b", y, q[0]);
                    end
                    void'(q.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(nxt);
                nxt = nxt + 4'd1;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
        end
        drive(1'b0, 4'h0, 4'h0, op_nand, 1'b0);
        out_ready = 1'b1;
        checks++;
        if (recv != 10 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: received %0d pending %0d, want 10 0", recv, q.size());
        end
    endtask

    task automatic test_chain(input int gap);
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 4'b0001, 4'b0010, op_or, 1'b0);
        for (int i = 1; i <= gap + 3; i++) begin
            @(negedge clk);
            if (i == 2) begin
                checks++;
                if (out_valid !== 1'b1 || y !== 4'b0011) begin
                    errors++;
                    $display("FAIL chain_first gap%0d: valid=%b y=%b, want 1 0011", gap, out_valid, y);
                end
            end
            if (i == gap + 3) begin
                checks++;
                if (out_valid !== 1'b1 || y !== 4'b0101) begin
                    errors++;
                    $display("FAIL chain_second gap%0d: valid=%b y=%b, want 1 0101", gap, out_valid, y);
                end
            end
            if (i == gap + 1) drive(1'b1, 4'b1111, 4'b0110, op_xor, 1'b1);
            else              drive(1'b0, 4'b1111, 4'b0000, op_nand, 1'b0);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 4'b1100, 4'b1010, op_nand, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'b1100, 4'b1010, op_and, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, op_nand, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || y !== 4'b0111) begin
            errors++;
            $display("FAIL midrst_prefill: valid=%b y=%b, want 1 0111", out_valid, y);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 4'h0 || zero !== 1'b0 || parity !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b y=%b zero=%b parity=%b in_ready=%b, want 0 0000 0 0 0",
                     out_valid, y, zero, parity, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'b1010, 4'b0000, op_nota, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, op_nand, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_dropped: stale out_valid=%b y=%b, want 0", out_valid, y);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== 4'b1111 || parity !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_chain_nota: valid=%b y=%b parity=%b zero=%b, want 1 1111 0 0",
                     out_valid, y, parity, zero);
        end
    endtask

    initial begin
        test_reset;
        test_op_sweep;
        test_zero_flag;
        test_backpressure;
        test_chain(0);
        test_chain(3);
        test_reset_midstream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
